// File: rtl/noc_trace_pkg.sv
// noc_trace_pkg: shared definitions for the NoC trace buffer.
//   - Flit width and OpenPiton header field positions.
//   - Header flit layout as a packed struct.
//   - Framing FSM state encoding.
package noc_trace_pkg;

    localparam int unsigned FLIT_W  = 64;
    localparam int unsigned LEN_HI  = 29;
    localparam int unsigned LEN_LO  = 22;
    localparam int unsigned TYPE_HI = 21;
    localparam int unsigned TYPE_LO = 14;
    localparam int unsigned LEN_W   = LEN_HI - LEN_LO + 1;
    localparam int unsigned TYPE_W  = TYPE_HI - TYPE_LO + 1;
    localparam int unsigned RSVD_W  = FLIT_W - 1 - LEN_HI;
    localparam int unsigned LOW_W   = TYPE_LO;

    // Header flit view; field widths follow the bit positions above.
    typedef struct packed {
        logic [RSVD_W-1:0] rsvd;
        logic [LEN_W-1:0]  len;
        logic [TYPE_W-1:0] msg_type;
        logic [LOW_W-1:0]  low;
    } hdr_t;

    typedef enum logic {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/noc_trace_fifo.sv
// noc_trace_fifo: flit storage with wrap-bit pointers.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   i_wr_en, i_wr_data   write at tail
//   i_rd_en              pop head
//   o_rd_data            head entry (meaningful only while not empty)
//   o_full, o_empty      occupancy flags from pointer compare
// Caller guarantees no write while full (unless popping) and no pop while empty.
module noc_trace_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    // Storage needs no reset; the head is only consumed when non-empty.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Same index with opposite wrap bit means full.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/noc_trace_buffer.sv
// noc_trace_buffer: credit-managed flit buffer behind the link tracing unit.
// Absorbs flits, returns credits upstream, relaunches flits downstream under
// its own credit counter, and tracks OpenPiton packet framing statistics.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   din_msg, din_val      incoming flit (always accepted unless full)
//   din_yum               one-cycle credit pulse per dequeued entry
//   dout_msg, dout_val    head flit, launched in the cycle dout_val is high
//   dout_yum              credit return from downstream
//   stat_clr              synchronous clear of statistics (not err_ovf)
//   flit_cnt, pkt_cnt     launched flits / completed packets
//   err_ovf               sticky overflow flag
//   last_msg_type         message type of the last launched header
//   last_hdr_ts           (NOC_TRACE_TIMESTAMP_EN only) cycle count at last header launch
// Optional feature macro: NOC_TRACE_TIMESTAMP_EN.
module noc_trace_buffer
    import noc_trace_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned OUT_CREDITS = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] din_msg,
    input  logic              din_val,
    output logic              din_yum,
    output logic [FLIT_W-1:0] dout_msg,
    output logic              dout_val,
    input  logic              dout_yum,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  flit_cnt,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              err_ovf,
`ifdef NOC_TRACE_TIMESTAMP_EN
    output logic [CNT_W-1:0]  last_hdr_ts,
`endif
    output logic [TYPE_W-1:0] last_msg_type
);

    localparam int unsigned CRED_W = $clog2(OUT_CREDITS + 1);

    logic [FLIT_W-1:0] w_head_raw;
    hdr_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_launch;
    logic              w_wr_en;
    logic              w_drop;

    logic [CRED_W-1:0] r_cred;

    fsm_state_t        r_state;
    fsm_state_t        w_state_nxt;
    logic [LEN_W-1:0]  r_rem;
    logic [LEN_W-1:0]  w_rem_nxt;
    logic              w_pkt_done;
    logic              w_hdr_launch;

    logic              r_yum;
    logic              r_err_ovf;
    logic [CNT_W-1:0]  r_flit_cnt;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [TYPE_W-1:0] r_last_type;

    // A write into a full buffer is still safe when the head leaves the same cycle.
    assign w_launch = !w_empty && (r_cred != '0);
    assign w_wr_en  = din_val && (!w_full || w_launch);
    assign w_drop   = din_val && w_full && !w_launch;
    assign w_head   = hdr_t'(w_head_raw);

    noc_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (FLIT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_data (din_msg),
        .i_rd_en   (w_launch),
        .o_rd_data (w_head_raw),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Downstream credit counter; a yum at the initial count is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cred <= CRED_W'(OUT_CREDITS);
        end else begin
            case ({w_launch, dout_yum})
                2'b10: r_cred <= r_cred - CRED_W'(1);
                2'b01: begin
                    if (r_cred < CRED_W'(OUT_CREDITS)) begin
                        r_cred <= r_cred + CRED_W'(1);
                    end
                end
                default: r_cred <= r_cred;
            endcase
        end
    end

    // Framing FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HDR;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Framing FSM next state; only a launch advances it.
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_pkt_done   = 1'b0;
        w_hdr_launch = 1'b0;
        if (w_launch) begin
            case (r_state)
                ST_HDR: begin
                    w_hdr_launch = 1'b1;
                    if (w_head.len == '0) begin
                        w_pkt_done = 1'b1;
                    end else begin
                        w_rem_nxt   = w_head.len;
                        w_state_nxt = ST_BODY;
                    end
                end
                ST_BODY: begin
                    w_rem_nxt = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_pkt_done  = 1'b1;
                        w_state_nxt = ST_HDR;
                    end
                end
                default: w_state_nxt = ST_HDR;
            endcase
        end
    end

    // Credit return, overflow flag and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_yum       <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_flit_cnt  <= '0;
            r_pkt_cnt   <= '0;
            r_last_type <= '0;
        end else begin
            r_yum <= w_launch;
            if (w_drop) begin
                r_err_ovf <= 1'b1;
            end
            if (stat_clr) begin
                r_flit_cnt  <= '0;
                r_pkt_cnt   <= '0;
                r_last_type <= '0;
            end else begin
                if (w_launch) begin
                    r_flit_cnt <= r_flit_cnt + CNT_W'(1);
                end
                if (w_pkt_done) begin
                    r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                end
                if (w_hdr_launch) begin
                    r_last_type <= w_head.msg_type;
                end
            end
        end
    end

`ifdef NOC_TRACE_TIMESTAMP_EN
    logic [CNT_W-1:0] r_ts;
    logic [CNT_W-1:0] r_last_hdr_ts;

    // Free-running cycle counter and header capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts          <= '0;
            r_last_hdr_ts <= '0;
        end else begin
            r_ts <= r_ts + CNT_W'(1);
            if (stat_clr) begin
                r_last_hdr_ts <= '0;
            end else if (w_hdr_launch) begin
                r_last_hdr_ts <= r_ts;
            end
        end
    end

    assign last_hdr_ts = r_last_hdr_ts;
`endif

    // Head is gated so dout_msg reads zero whenever nothing is launched.
    assign dout_val      = w_launch;
    assign dout_msg      = w_launch ? FLIT_W'(w_head) : '0;
    assign din_yum       = r_yum;
    assign err_ovf       = r_err_ovf;
    assign flit_cnt      = r_flit_cnt;
    assign pkt_cnt       = r_pkt_cnt;
    assign last_msg_type = r_last_type;

endmodule

// File: tb/tb_noc_trace_buffer.sv
// tb_noc_trace_buffer: directed scoreboard bench for noc_trace_buffer
// (DEPTH=4, OUT_CREDITS=4, CNT_W=32). Optional NOC_TRACE_TIMESTAMP_EN.
module tb_noc_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] din_msg;
    logic        din_val;
    logic        din_yum;
    logic [63:0] dout_msg;
    logic        dout_val;
    logic        dout_yum;
    logic        stat_clr;
    logic [31:0] flit_cnt;
    logic [31:0] pkt_cnt;
    logic        err_ovf;
    logic [7:0]  last_msg_type;
`ifdef NOC_TRACE_TIMESTAMP_EN
    logic [31:0] last_hdr_ts;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_launch = 0;
    int n_yum    = 0;
    int cyc      = 0;
    int last_launch_cyc = 0;
    logic obs_val;
    logic obs_yum;
    logic [63:0] sb[$];

    noc_trace_buffer #(
        .DEPTH       (4),
        .OUT_CREDITS (4),
        .CNT_W       (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din_msg       (din_msg),
        .din_val       (din_val),
        .din_yum       (din_yum),
        .dout_msg      (dout_msg),
        .dout_val      (dout_val),
        .dout_yum      (dout_yum),
        .stat_clr      (stat_clr),
        .flit_cnt      (flit_cnt),
        .pkt_cnt       (pkt_cnt),
        .err_ovf       (err_ovf),
`ifdef NOC_TRACE_TIMESTAMP_EN
        .last_hdr_ts   (last_hdr_ts),
`endif
        .last_msg_type (last_msg_type)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] len, input logic [7:0] typ,
                                       input logic [33:0] tag);
        return {tag, len, typ, 14'h2A5};
    endfunction

    // Body flits carry all-ones in the header fields so misparsing is visible.
    function automatic logic [63:0] body(input logic [7:0] idx);
        return 64'hA5A5_0000_3FFF_FF00 | 64'(idx);
    endfunction

    // Advance one clock; sample outputs 1 time unit after the edge and score launches.
    task automatic cycle();
        logic [63:0] exp;
        @(posedge clk);
        #1;
        cyc++;
        obs_val = dout_val;
        obs_yum = din_yum;
        if (din_yum === 1'b1) n_yum++;
        if (dout_val === 1'b1) begin
            n_launch++;
            last_launch_cyc = cyc;
            chk("sb_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("dout_msg", dout_msg, exp);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        din_val  = 1'b0;
        din_msg  = '0;
        dout_yum = 1'b0;
        stat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout_val", 64'(dout_val), 64'd0);
        chk("rst_din_yum", 64'(din_yum), 64'd0);
        chk("rst_dout_msg", dout_msg, 64'd0);
        chk("rst_flit_cnt", 64'(flit_cnt), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_err_ovf", 64'(err_ovf), 64'd0);
        chk("rst_type", 64'(last_msg_type), 64'd0);
        rst_n = 1'b1;
        cyc   = 0;

        // Single header, len 0, type 0x0A
        din_msg = mk(8'd0, 8'h0A, 34'd1);
        din_val = 1'b1;
        sb.push_back(din_msg);
        cycle();
        din_val = 1'b0;
        chk("t1_latency", 64'(obs_val), 64'd1);
        cycle();
        chk("t1_yum", 64'(obs_yum), 64'd1);
        chk("t1_val_done", 64'(obs_val), 64'd0);
        chk("t1_flit_cnt", 64'(flit_cnt), 64'd1);
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("t1_type", 64'(last_msg_type), 64'h0A);

        // Return the used credit, then extra yums that must saturate
        dout_yum = 1'b1;
        repeat (4) cycle();
        dout_yum = 1'b0;
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        chk("clr_flit_cnt", 64'(flit_cnt), 64'd0);
        chk("clr_pkt_cnt", 64'(pkt_cnt), 64'd0);

        // Four-flit packet (len 3) back to back
        for (int i = 0; i < 4; i++) begin
            din_msg = (i == 0) ? mk(8'd3, 8'h14, 34'd2) : body(8'(i));
            din_val = 1'b1;
            sb.push_back(din_msg);
            cycle();
            chk("t2_b2b_val", 64'(obs_val), 64'd1);
            chk("t2_pkt_early", 64'(pkt_cnt), 64'd0);
        end
        din_val = 1'b0;
        cycle();
        chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("t2_flit_cnt", 64'(flit_cnt), 64'd4);
        chk("t2_type", 64'(last_msg_type), 64'h14);
        chk("t2_no_credit", 64'(obs_val), 64'd0);

        // Restore 4 credits plus 3 surplus yums
        dout_yum = 1'b1;
        repeat (7) cycle();
        dout_yum = 1'b0;

        // Six flits, no yum: exactly four launch
        n_launch = 0;
        n_yum    = 0;
        for (int i = 0; i < 6; i++) begin
            din_msg = mk(8'd0, 8'(8'h30 + i), 34'(16 + i));
            din_val = 1'b1;
            sb.push_back(din_msg);
            cycle();
        end
        din_val = 1'b0;
        repeat (4) cycle();
        chk("t3_launches", 64'(n_launch), 64'd4);
        chk("t3_yums", 64'(n_yum), 64'd4);
        chk("t3_no_ovf", 64'(err_ovf), 64'd0);
        chk("t3_type", 64'(last_msg_type), 64'h33);
        dout_yum = 1'b1;
        cycle();
        dout_yum = 1'b0;
        chk("t3_yum_launch", 64'(obs_val), 64'd1);
        cycle();
        chk("t3_one_only", 64'(obs_val), 64'd0);
        dout_yum = 1'b1;
        cycle();
        dout_yum = 1'b0;
        chk("t3_last_held", 64'(obs_val), 64'd1);
        cycle();
        chk("t3_drained", 64'(sb.size()), 64'd0);

        // Zero credits, five flits into DEPTH=4: fifth dropped
        for (int i = 0; i < 5; i++) begin
            din_msg = mk(8'd0, 8'(8'h40 + i), 34'(32 + i));
            din_val = 1'b1;
            if (i < 4) sb.push_back(din_msg);
            cycle();
            chk("t4_hold", 64'(obs_val), 64'd0);
        end
        din_val = 1'b0;
        cycle();
        chk("t4_err_ovf", 64'(err_ovf), 64'd1);
        n_launch = 0;
        n_yum    = 0;
        dout_yum = 1'b1;
        repeat (4) cycle();
        dout_yum = 1'b0;
        repeat (4) cycle();
        chk("t4_launches", 64'(n_launch), 64'd4);
        chk("t4_yums", 64'(n_yum), 64'd4);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Reset mid-packet: header len 3 plus one body launched, second body in flight
        dout_yum = 1'b1;
        repeat (3) cycle();
        dout_yum = 1'b0;
        din_msg = mk(8'd3, 8'h55, 34'd48);
        din_val = 1'b1;
        sb.push_back(din_msg);
        cycle();
        din_msg = body(8'd9);
        sb.push_back(din_msg);
        cycle();
        din_msg = body(8'd10);
        sb.push_back(din_msg);
        cycle();
        din_val = 1'b0;
        chk("mid_val", 64'(obs_val), 64'd1);
        chk("mid_yum", 64'(obs_yum), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_dout_val", 64'(dout_val), 64'd0);
        chk("mr_dout_msg", dout_msg, 64'd0);
        chk("mr_din_yum", 64'(din_yum), 64'd0);
        chk("mr_flit_cnt", 64'(flit_cnt), 64'd0);
        chk("mr_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("mr_err_ovf", 64'(err_ovf), 64'd0);
        chk("mr_type", 64'(last_msg_type), 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cyc      = 0;
        n_launch = 0;

        // After reset: first flit is a header; four credits available again
        for (int i = 0; i < 5; i++) begin
            din_msg = mk(8'd0, 8'(8'h60 + i), 34'(64 + i));
            din_val = 1'b1;
            sb.push_back(din_msg);
            cycle();
        end
        din_val = 1'b0;
        repeat (4) cycle();
        chk("pr_launches", 64'(n_launch), 64'd4);
        chk("pr_pkt_cnt", 64'(pkt_cnt), 64'd4);
        chk("pr_flit_cnt", 64'(flit_cnt), 64'd4);
        chk("pr_type", 64'(last_msg_type), 64'h63);
        chk("pr_held", 64'(sb.size()), 64'd1);
`ifdef NOC_TRACE_TIMESTAMP_EN
        chk("ts_last_hdr", 64'(last_hdr_ts), 64'(last_launch_cyc));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
